// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch (IF) and load/store (LS), one transaction in flight.
// Define ARB_RR_EN for round-robin tie-breaking; by default LS has fixed priority.
module mem_port_arbiter #(
    parameter int DATA_W      = 32,
    parameter int MEM_DEPTH   = 2048,
    parameter int MEM_AW      = 11,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [31:0]       if_req_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    output logic              if_rsp_err,

    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [31:0]       ls_req_addr,
    input  logic              ls_req_we,
    input  logic [3:0]        ls_req_be,
    input  logic [DATA_W-1:0] ls_req_wdata,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rsp_data,
    output logic              ls_rsp_err,

    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    generate
        if (MEM_AW != $clog2(MEM_DEPTH)) begin : g_bad_aw
            $error("MEM_AW must equal clog2(MEM_DEPTH)");
        end
        if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_lat
            $error("MEM_LATENCY must be in 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic        r_port_ls;
    logic        r_we;
    logic        r_err;

    logic        w_idle;
    logic        w_ls_wins_tie;
    logic        w_grant_ls;
    logic        w_grant_if;
    logic        w_if_err;
    logic        w_ls_err;
    logic        w_acc_err;
    logic [DATA_W-1:0] w_rsp_data;

`ifdef ARB_RR_EN
    logic        r_last_ls;
    assign w_ls_wins_tie = !r_last_ls;
`else
    assign w_ls_wins_tie = 1'b1;
`endif

    // Readies are forced low while reset is held so nothing can handshake.
    assign w_idle       = reset && (r_state == ST_IDLE);
    assign w_grant_ls   = w_idle && ls_req_valid && (!if_req_valid || w_ls_wins_tie);
    assign w_grant_if   = w_idle && if_req_valid && !w_grant_ls;
    assign if_req_ready = w_grant_if;
    assign ls_req_ready = w_grant_ls;

    // Stores may be misaligned (byte enables pick the lanes); fetches and loads may not.
    assign w_if_err  = (if_req_addr[1:0] != 2'b00) || (if_req_addr[31:MEM_AW+2] != '0);
    assign w_ls_err  = (!ls_req_we && (ls_req_addr[1:0] != 2'b00)) ||
                       (ls_req_addr[31:MEM_AW+2] != '0);
    assign w_acc_err = w_grant_ls ? w_ls_err : w_if_err;

    assign w_rsp_data = (r_err || r_we) ? '0 : mem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_port_ls    <= 1'b0;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            if_rsp_err   <= 1'b0;
            ls_rsp_valid <= 1'b0;
            ls_rsp_data  <= '0;
            ls_rsp_err   <= 1'b0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_be       <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
`ifdef ARB_RR_EN
            r_last_ls    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_ls || w_grant_if) begin
                        r_state   <= ST_ACCESS;
                        r_port_ls <= w_grant_ls;
                        r_we      <= w_grant_ls && ls_req_we;
                        r_err     <= w_acc_err;
                        mem_en    <= !w_acc_err;
                        mem_we    <= w_grant_ls && ls_req_we && !w_acc_err;
                        mem_be    <= w_grant_ls ? ls_req_be : 4'b0000;
                        mem_addr  <= w_grant_ls ? ls_req_addr[MEM_AW+1:2]
                                                : if_req_addr[MEM_AW+1:2];
                        mem_wdata <= w_grant_ls ? ls_req_wdata : '0;
`ifdef ARB_RR_EN
                        r_last_ls <= w_grant_ls;
`endif
                    end
                end
                ST_ACCESS: begin
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    r_cnt   <= 2'(MEM_LATENCY - 1);
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_state <= ST_RESP;
                        if (r_port_ls) begin
                            ls_rsp_valid <= 1'b1;
                            ls_rsp_data  <= w_rsp_data;
                            ls_rsp_err   <= r_err;
                        end else begin
                            if_rsp_valid <= 1'b1;
                            if_rsp_data  <= w_rsp_data;
                            if_rsp_err   <= r_err;
                        end
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                ST_RESP: begin
                    if_rsp_valid <= 1'b0;
                    ls_rsp_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int LAT   = 3;
    localparam int AW    = 11;
    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
    logic [31:0] if_req_addr, if_rsp_data;
    logic        ls_req_valid, ls_req_ready, ls_req_we, ls_rsp_valid, ls_rsp_err;
    logic [3:0]  ls_req_be;
    logic [31:0] ls_req_addr, ls_req_wdata, ls_rsp_data;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .DATA_W(32), .MEM_DEPTH(DEPTH), .MEM_AW(AW), .MEM_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
        .ls_req_we(ls_req_we), .ls_req_be(ls_req_be), .ls_req_wdata(ls_req_wdata),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data), .ls_rsp_err(ls_rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // SRAM with LAT-cycle read pipeline; non-read slots carry junk so early sampling shows up.
    logic [31:0] sram [0:DEPTH-1];
    logic [31:0] rd_pipe [0:LAT-1];
    int unsigned fill = 0;
    always @(posedge clk) begin
        fill = fill + 1;
        if (mem_en && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) sram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
        rd_pipe[0] <= (mem_en && !mem_we) ? sram[mem_addr] : {16'hBAD0, fill[15:0]};
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    // Transaction-level reference state
    logic [31:0] ref_mem [0:DEPTH-1];
    int          cyc, free_cyc;
    bit          in_rst, last_ls;
    bit          acc_pend;
    int          acc_cyc;
    logic [AW-1:0] acc_addr;
    logic        acc_we;
    logic [3:0]  acc_be;
    logic [31:0] acc_wd;
    bit          rsp_pend, rsp_ls;
    int          rsp_cyc;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int          errors, checks;
    bit          got_if, got_ls;
    logic [31:0] last_if_data, last_ls_data;
    logic        last_if_err, last_ls_err;
    int          last_ls_cyc, prev_ls_cyc;
    int          n_if_gnt, n_ls_gnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        in_rst   = 1'b1;
        acc_pend = 1'b0;
        rsp_pend = 1'b0;
        last_ls  = 1'b0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit iv, input logic [31:0] ia, input bit lv, input logic [31:0] la,
                        input bit lwe, input logic [3:0] lbe, input logic [31:0] lwd);
        bit          idle, e_gl, e_gi, e_men, we, err;
        logic [31:0] a, d;
        logic [AW-1:0] w;
        if_req_valid = iv;  if_req_addr = ia;
        ls_req_valid = lv;  ls_req_addr = la;
        ls_req_we = lwe;    ls_req_be = lbe;  ls_req_wdata = lwd;
        #1;
        idle = !in_rst && (cyc >= free_cyc);
`ifdef ARB_RR_EN
        e_gl = idle && lv && (!iv || !last_ls);
`else
        e_gl = idle && lv;
`endif
        e_gi = idle && iv && !e_gl;
        check("if_req_ready", {31'd0, if_req_ready}, {31'd0, e_gi});
        check("ls_req_ready", {31'd0, ls_req_ready}, {31'd0, e_gl});
        if (if_req_ready === 1'b1) n_if_gnt++;
        if (ls_req_ready === 1'b1) n_ls_gnt++;

        e_men = acc_pend && (cyc == acc_cyc);
        check("mem_en", {31'd0, mem_en}, {31'd0, e_men});
        if (e_men) begin
            check("mem_addr", {21'd0, mem_addr}, {21'd0, acc_addr});
            check("mem_we", {31'd0, mem_we}, {31'd0, acc_we});
            check("mem_be", {28'd0, mem_be}, {28'd0, acc_be});
            if (acc_we) check("mem_wdata", mem_wdata, acc_wd);
        end
        if (acc_pend && cyc >= acc_cyc) acc_pend = 1'b0;

        check("if_rsp_valid", {31'd0, if_rsp_valid}, {31'd0, rsp_pend && cyc == rsp_cyc && !rsp_ls});
        check("ls_rsp_valid", {31'd0, ls_rsp_valid}, {31'd0, rsp_pend && cyc == rsp_cyc && rsp_ls});
        if (rsp_pend && cyc == rsp_cyc) begin
            if (rsp_ls) begin
                check("ls_rsp_data", ls_rsp_data, rsp_data);
                check("ls_rsp_err", {31'd0, ls_rsp_err}, {31'd0, rsp_err});
            end else begin
                check("if_rsp_data", if_rsp_data, rsp_data);
                check("if_rsp_err", {31'd0, if_rsp_err}, {31'd0, rsp_err});
            end
            $display("cycle %0d: %s response data=%08h err=%0d", cyc, rsp_ls ? "LS" : "IF",
                     rsp_ls ? ls_rsp_data : if_rsp_data, rsp_ls ? ls_rsp_err : if_rsp_err);
            rsp_pend = 1'b0;
        end
        if (if_rsp_valid === 1'b1) begin
            got_if = 1'b1; last_if_data = if_rsp_data; last_if_err = if_rsp_err;
        end
        if (ls_rsp_valid === 1'b1) begin
            got_ls = 1'b1; last_ls_data = ls_rsp_data; last_ls_err = ls_rsp_err;
            prev_ls_cyc = last_ls_cyc; last_ls_cyc = cyc;
        end

        if (e_gl || e_gi) begin
            a   = e_gl ? la : ia;
            we  = e_gl && lwe;
            err = (a >= 32'(4 * DEPTH)) || (!we && (a % 4 != 0));
            w   = AW'(a / 4);
            d   = 32'd0;
            if (!err && we) begin
                for (int b = 0; b < 4; b++)
                    if (lbe[b]) ref_mem[w][8*b +: 8] = lwd[8*b +: 8];
            end else if (!err) begin
                d = ref_mem[w];
            end
            last_ls  = e_gl;
            acc_pend = !err;  acc_cyc = cyc + 1;
            acc_addr = w;     acc_we = we;
            acc_be   = e_gl ? lbe : 4'b0000;  acc_wd = lwd;
            rsp_pend = 1'b1;  rsp_cyc = cyc + 2 + LAT;  rsp_ls = e_gl;
            rsp_data = d;     rsp_err = err;
            free_cyc = cyc + 3 + LAT;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        int r;
        r = $urandom_range(0, 15);
        a = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
        if (r == 0)      a = a | 32'h0000_8000;
        else if (r <= 2) a[1:0] = 2'($urandom_range(1, 3));
        else if (r == 3) a = 32'h0000_1FFC;
        else if (r == 4) a = 32'h0000_2000;
        return a;
    endfunction

    initial begin
        int unsigned v;
        errors = 0; checks = 0; cyc = 0; free_cyc = 0;
        got_if = 0; got_ls = 0; last_ls_cyc = 0; prev_ls_cyc = 0;
        n_if_gnt = 0; n_ls_gnt = 0;
        last_if_data = 0; last_ls_data = 0; last_if_err = 0; last_ls_err = 0;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            sram[i] = v; ref_mem[i] = v;
        end
        sram[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        sram[8] = 32'hFFFFFFFF; ref_mem[8] = 32'hFFFFFFFF;

        // Reset held: requests must not be accepted and outputs stay zero
        model_reset();
        reset = 1'b0;
        if_req_valid = 0; ls_req_valid = 0;
        @(negedge clk);
        step(1'b1, 32'h10, 1'b1, 32'h20, 1'b0, 4'hF, 32'd0);
        step(1'b1, 32'h10, 1'b1, 32'h20, 1'b0, 4'hF, 32'd0);
        check("rst_if_rsp_data", if_rsp_data, 32'd0);
        check("rst_ls_rsp_data", ls_rsp_data, 32'd0);
        reset = 1'b1; in_rst = 1'b0; free_cyc = cyc;

        // Single fetch of word 4
        got_if = 0;
        step(1'b1, 32'h10, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
        idle_cycles(LAT + 3);
        check("fetch_seen", {31'd0, got_if}, 32'd1);
        check("fetch_data", last_if_data, 32'hDEADBEEF);
        check("fetch_err", {31'd0, last_if_err}, 32'd0);

        // Half-word store then load of the same word
        got_ls = 0;
        step(1'b0, 32'd0, 1'b1, 32'h20, 1'b1, 4'b0011, 32'h12345678);
        idle_cycles(LAT + 3);
        check("store_seen", {31'd0, got_ls}, 32'd1);
        check("store_data", last_ls_data, 32'd0);
        got_ls = 0;
        step(1'b0, 32'd0, 1'b1, 32'h20, 1'b0, 4'b0000, 32'd0);
        idle_cycles(LAT + 3);
        check("load_seen", {31'd0, got_ls}, 32'd1);
        check("load_data", last_ls_data, 32'hFFFF5678);

        // Both ports requesting every cycle
        n_if_gnt = 0; n_ls_gnt = 0;
        for (int k = 0; k < 200 && (n_if_gnt + n_ls_gnt) < 6; k++)
            step(1'b1, {25'd0, 5'($urandom_range(0, 31)), 2'b00},
                 1'b1, {25'd0, 5'($urandom_range(0, 31)), 2'b00}, 1'b0, 4'd0, 32'd0);
        idle_cycles(LAT + 3);
`ifdef ARB_RR_EN
        check("tie_ls_grants", n_ls_gnt, 32'd3);
        check("tie_if_grants", n_if_gnt, 32'd3);
`else
        check("tie_ls_grants", n_ls_gnt, 32'd6);
        check("tie_if_grants", n_if_gnt, 32'd0);
`endif

        // Error responses
        got_if = 0;
        step(1'b1, 32'h2002, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
        idle_cycles(LAT + 3);
        check("fetch_misal_err", {31'd0, last_if_err}, 32'd1);
        check("fetch_misal_data", last_if_data, 32'd0);
        got_ls = 0;
        step(1'b0, 32'd0, 1'b1, 32'h8000, 1'b0, 4'd0, 32'd0);
        idle_cycles(LAT + 3);
        check("load_oor_seen", {31'd0, got_ls}, 32'd1);
        check("load_oor_err", {31'd0, last_ls_err}, 32'd1);

        // Back-to-back loads: responses spaced by the full transaction period
        for (int k = 0; k < 3 * (LAT + 3) + 1; k++)
            step(1'b0, 32'd0, 1'b1, {25'd0, 5'(k), 2'b00}, 1'b0, 4'd0, 32'd0);
        check("b2b_gap", last_ls_cyc - prev_ls_cyc, 32'(3 + LAT));
        idle_cycles(LAT + 3);

        // Reset during WAIT drops the load with no response
        step(1'b0, 32'd0, 1'b1, 32'h20, 1'b0, 4'd0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
        reset = 1'b0;
        model_reset();
        step(1'b1, 32'h10, 1'b1, 32'h20, 1'b0, 4'd0, 32'd0);
        check("wait_rst_ls_data", ls_rsp_data, 32'd0);
        step(1'b1, 32'h10, 1'b1, 32'h20, 1'b0, 4'd0, 32'd0);
        reset = 1'b1; in_rst = 1'b0; free_cyc = cyc;
        got_ls = 0;
        step(1'b0, 32'd0, 1'b1, 32'h20, 1'b0, 4'd0, 32'd0);
        idle_cycles(LAT + 3);
        check("post_rst_load", last_ls_data, 32'hFFFF5678);

        // Random traffic
        for (int k = 0; k < 400; k++)
            step(1'($urandom_range(0, 1)), rnd_addr(), 1'($urandom_range(0, 1)), rnd_addr(),
                 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
        idle_cycles(LAT + 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
